// File: rtl/led7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment/anode bus, waits for a stable
// run of STABLE_CYCLES samples, and decodes the pattern into per-digit nibbles.
module led7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_w_clk,
  input  logic        i_w_reset,
  input  logic [6:0]  i_w_7seg,
  input  logic [7:0]  i_w_an,
  output logic [31:0] o_w_digits,
  output logic [7:0]  o_w_valid,
  output logic [7:0]  o_w_err,
  output logic        o_w_an_err,
  output logic        o_w_update,
  output logic [2:0]  o_w_upd_idx
);

  localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
  localparam logic [14:0] BLANK  = {8'hFF, 7'h7F};

  logic [14:0] samp_q;
  logic [14:0] cur;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;

  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  err_q, err_d;
  logic        an_err_q, an_err_d;
  logic        upd_q, upd_d;
  logic [2:0]  idx_q, idx_d;

  logic [3:0]  low_cnt;
  logic [2:0]  low_idx;
  logic        seg_legal;
  logic [3:0]  seg_val;

  assign cur = {i_w_an, i_w_7seg};

  // Capture fires only on the transition into saturation, so a held input
  // yields exactly one capture per run.
  always_comb begin
    cnt_d = cnt_q;
    if (cur != samp_q) begin
      cnt_d = 4'd1;
    end else if (cnt_q != STABLE) begin
      cnt_d = cnt_q + 4'd1;
    end
    capture = (cnt_d == STABLE) && (cnt_q != STABLE);
  end

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (!i_w_an[k]) begin
        low_cnt = low_cnt + 4'd1;
        low_idx = 3'(k);
      end
    end
  end

  always_comb begin
    seg_legal = 1'b1;
    seg_val   = '0;
    unique case (i_w_7seg)
      7'h40:   seg_val = 4'h0;
      7'h79:   seg_val = 4'h1;
      7'h24:   seg_val = 4'h2;
      7'h30:   seg_val = 4'h3;
      7'h19:   seg_val = 4'h4;
      7'h12:   seg_val = 4'h5;
      7'h02:   seg_val = 4'h6;
      7'h78:   seg_val = 4'h7;
      7'h00:   seg_val = 4'h8;
      7'h10:   seg_val = 4'h9;
      7'h08:   seg_val = 4'hA;
      7'h03:   seg_val = 4'hB;
      7'h46:   seg_val = 4'hC;
      7'h21:   seg_val = 4'hD;
      7'h06:   seg_val = 4'hE;
      7'h0E:   seg_val = 4'hF;
      default: seg_legal = 1'b0;
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    an_err_d = an_err_q;
    upd_d    = 1'b0;
    idx_d    = idx_q;
    if (capture) begin
      if (low_cnt == 4'd1) begin
        upd_d = 1'b1;
        idx_d = low_idx;
        if (seg_legal) begin
          digits_d[{low_idx, 2'b00} +: 4] = seg_val;
          valid_d[low_idx] = 1'b1;
          err_d[low_idx]   = 1'b0;
        end else begin
          err_d[low_idx] = 1'b1;
        end
      end else if (low_cnt > 4'd1) begin
        an_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      samp_q   <= BLANK;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      an_err_q <= 1'b0;
      upd_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      samp_q   <= cur;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      an_err_q <= an_err_d;
      upd_q    <= upd_d;
      idx_q    <= idx_d;
    end
  end

  assign o_w_digits  = digits_q;
  assign o_w_valid   = valid_q;
  assign o_w_err     = err_q;
  assign o_w_an_err  = an_err_q;
  assign o_w_update  = upd_q;
  assign o_w_upd_idx = idx_q;

endmodule

// File: tb/tb_led7_scan_decoder.sv
// Directed plus randomized stimulus for led7_scan_decoder, checked against a
// history-queue reference model of the capture rules.
module tb_led7_scan_decoder;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [7:0]  an  = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  valid, err;
  logic        an_err, upd;
  logic [2:0]  upd_idx;

  always #5 clk = ~clk;

  led7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .i_w_clk    (clk),
    .i_w_reset  (rst),
    .i_w_7seg   (seg),
    .i_w_an     (an),
    .o_w_digits (digits),
    .o_w_valid  (valid),
    .o_w_err    (err),
    .o_w_an_err (an_err),
    .o_w_update (upd),
    .o_w_upd_idx(upd_idx)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  logic [14:0] hist [$];
  logic [3:0]  m_dig [8];
  logic [7:0]  m_valid, m_err;
  logic        m_anerr, m_upd;
  logic [2:0]  m_idx;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  logic [2:0] last_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] a, input logic [6:0] s, input logic r);
    int n, lows, k, v;
    logic same;
    m_upd = 1'b0;
    if (r) begin
      hist.delete();
      for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
      m_valid = '0; m_err = '0; m_anerr = 1'b0; m_idx = '0;
      return;
    end
    hist.push_back({a, s});
    if (hist.size() > S + 1) void'(hist.pop_front());
    n = hist.size();
    if (n < S) return;
    same = 1'b1;
    for (int i = 1; i < S; i++) if (hist[n-1-i] != hist[n-1]) same = 1'b0;
    if (!same) return;
    if (n > S && hist[n-1-S] == hist[n-1]) return;
    lows = 0; k = 0;
    for (int i = 0; i < 8; i++) if (!a[i]) begin lows++; k = i; end
    if (lows > 1) begin
      m_anerr = 1'b1;
    end else if (lows == 1) begin
      m_upd = 1'b1;
      m_idx = 3'(k);
      v = -1;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == s) v = i;
      if (v >= 0) begin
        m_dig[k] = 4'(v); m_valid[k] = 1'b1; m_err[k] = 1'b0;
      end else begin
        m_err[k] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = m_dig[i];
    chk("digits", digits, d);
    chk("valid", {24'h0, valid}, {24'h0, m_valid});
    chk("err", {24'h0, err}, {24'h0, m_err});
    chk("an_err", {31'h0, an_err}, {31'h0, m_anerr});
    chk("update", {31'h0, upd}, {31'h0, m_upd});
    if (m_upd) chk("upd_idx", {29'h0, upd_idx}, {29'h0, m_idx});
  endtask

  task automatic tick(input logic [7:0] a, input logic [6:0] s, input logic r);
    @(negedge clk);
    an = a; seg = s; rst = r;
    @(posedge clk);
    model_edge(a, s, r);
    #1;
    if (upd === 1'b1) begin pulses++; last_idx = upd_idx; end
    check_model();
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] s, input int cycles);
    for (int i = 0; i < cycles; i++) tick(a, s, 1'b0);
  endtask

  initial begin
    // reset with random inputs, then blank input
    tick(8'($urandom), 7'($urandom), 1'b1);
    tick(8'($urandom), 7'($urandom), 1'b1);
    pulses = 0;
    hold(8'hFF, 7'h7F, 6);
    chk("reset_pulses", pulses, 0);
    chk("reset_digits", digits, 32'h0);

    // single capture, visible right after edge S
    hold(8'hFE, 7'h24, S - 1);
    chk("single_early", {31'h0, upd}, 32'h0);
    tick(8'hFE, 7'h24, 1'b0);
    chk("single_upd", {31'h0, upd}, 32'h1);
    chk("single_idx", {29'h0, upd_idx}, 32'h0);
    hold(8'hFE, 7'h24, 6);
    chk("single_pulses", pulses, 1);
    chk("single_nib", {28'h0, digits[3:0]}, 32'h2);
    chk("single_valid", {24'h0, valid}, 32'h01);

    // glitch rejection then full scan, back-to-back captures
    pulses = 0;
    hold(8'hFD, 7'h79, S - 1);
    chk("glitch_pulses", pulses, 0);
    for (int k = 0; k < 8; k++) begin
      hold(~(8'h01 << k), seg_tab[k], S);
      chk("scan_upd", {31'h0, upd}, 32'h1);
      chk("scan_idx", {29'h0, upd_idx}, k);
    end
    chk("scan_pulses", pulses, 8);
    chk("scan_digits", digits, 32'h76543210);
    chk("scan_valid", {24'h0, valid}, 32'hFF);

    // illegal then legal on digit 5
    pulses = 0;
    hold(8'hDF, 7'h7F, S);
    chk("illegal_err", {24'h0, err}, 32'h20);
    chk("illegal_pulses", pulses, 1);
    chk("illegal_idx", {29'h0, last_idx}, 32'h5);
    chk("illegal_digits", digits, 32'h76543210);
    hold(8'hDF, 7'h0E, S);
    chk("legal_digits", digits, 32'h76F43210);
    chk("legal_err", {24'h0, err}, 32'h00);
    chk("legal_valid", {24'h0, valid}, 32'hFF);

    // multiple low anodes, then blank, then reset
    pulses = 0;
    hold(8'hFC, 7'h40, 6);
    chk("anerr_set", {31'h0, an_err}, 32'h1);
    hold(8'hFF, 7'h40, 6);
    chk("blank_pulses", pulses, 0);
    chk("blank_anerr", {31'h0, an_err}, 32'h1);
    chk("blank_digits", digits, 32'h76F43210);
    tick(8'hFF, 7'h7F, 1'b1);
    chk("reset_anerr", {31'h0, an_err}, 32'h0);

    // reset mid-run discards the run
    pulses = 0;
    hold(8'hF7, 7'h00, 1);
    tick(8'hF7, 7'h00, 1'b1);
    hold(8'hF7, 7'h00, S - 1);
    chk("midrst_none", pulses, 0);
    tick(8'hF7, 7'h00, 1'b0);
    chk("midrst_upd", {31'h0, upd}, 32'h1);
    chk("midrst_nib", {28'h0, digits[15:12]}, 32'h8);

    // randomized runs of random length
    for (int t = 0; t < 120; t++) begin
      logic [7:0] ra;
      logic [6:0] rs;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      ra = ~(8'h01 << $urandom_range(0, 7));
      else if (sel < 8) ra = 8'hFF;
      else              ra = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom);
      if ($urandom_range(0, 24) == 0) tick(ra, rs, 1'b1);
      else hold(ra, rs, int'($urandom_range(1, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led7_scan_decoder.md
# led7_scan_decoder

Receive-side companion to the `led7` seven-segment driver. It monitors a time-multiplexed 8-digit display bus (active-low segments and active-low anodes), waits until each segment/anode combination has been stable for a programmable number of cycles, and decodes the segment pattern back into a hex nibble. Each nibble is stored in a per-digit register file. The block sits between the display driver outputs and any checker, loopback, or readback logic that needs the displayed values as data.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive identical input samples required before a capture. Legal range is 2..15.
- `i_w_clk`  input  1: system clock; all logic is on the rising edge.
- `i_w_reset`  input  1: synchronous, active-high reset.
- `i_w_7seg`  input  7: segment bus, active-low, bit order {g,f,e,d,c,b,a} (bit0 = a).
- `i_w_an`  input  8: anode bus, active-low; bit k low selects digit k.
- `o_w_digits`  output  32: decoded digits; digit k occupies bits [4k+3:4k].
- `o_w_valid`  output  8: bit k is set once digit k has captured a legal pattern.
- `o_w_err`  output  8: bit k is set when the last capture for digit k was an illegal pattern.
- `o_w_an_err`  output  1: sticky flag; set when a stable anode value has more than one low bit.
- `o_w_update`  output  1: one-cycle pulse on every capture, legal or illegal.
- `o_w_upd_idx`  output  3: digit index of the current capture; meaningful only while `o_w_update` is 1.

## Operation
- **Legal patterns** (hex, active-low), digit value : pattern:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Any other 7-bit value is illegal.
- **Sampling:** `{i_w_an, i_w_7seg}` is registered every cycle. A stability counter tracks the run of consecutive identical samples:
  - The counter restarts on any difference between samples.
  - It saturates at `STABLE_CYCLES`.
  - A capture fires exactly once per stable run, on the edge where the run length reaches `STABLE_CYCLES`. Holding the input longer produces no further captures.
- **Capture, anode one-hot-low (index k):**
  - Legal pattern: `digits[k]` takes the decoded value, `valid[k]` is set to 1, `err[k]` is cleared to 0.
  - Illegal pattern: `err[k]` is set to 1; `digits[k]` and `valid[k]` are unchanged.
  - In both cases `o_w_update` is 1 for one cycle and `o_w_upd_idx` = k.
- **Capture, anode all-ones (blank):** no state changes and no update pulse.
- **Capture, anode with two or more low bits:**
  - `o_w_an_err` is set to 1 and stays set until reset.
  - Digits, valid and err are unchanged; no update pulse.
- **Other digits:** a capture for digit k never modifies any other digit's `digits`, `valid` or `err` bits.

## Timing
- **Reset:** `i_w_reset` high at an edge dominates all other activity.
  - Outputs after that edge: `o_w_digits` = 0, `o_w_valid` = 0, `o_w_err` = 0, `o_w_an_err` = 0, `o_w_update` = 0, `o_w_upd_idx` = 0.
  - Internal sample register is set to the blank value {8'hFF, 7'h7F}; the stability counter is cleared.
- **Latency:** call the first rising edge that samples a new input value edge 1. If the input is held through edge `STABLE_CYCLES`, the captured outputs and the `o_w_update` pulse are visible immediately after edge `STABLE_CYCLES`. `o_w_update` drops after the next edge.
- **Input change:** a change at or before the would-be capture edge aborts that capture; the new value starts a fresh run counting from 1.
- **Reset mid-run:** the run is discarded. After reset releases, a capture requires `STABLE_CYCLES` fresh samples, with edge 1 being the first non-reset edge.
- **Back-to-back digits:** a minimum of `STABLE_CYCLES` cycles per digit is sufficient. Consecutive captures may be exactly `STABLE_CYCLES` cycles apart.

## Test plan
- **Reset:** assert reset for 2 cycles with random inputs -> all outputs 0 and no update pulse during or after reset while the input stays blank.
- **Single capture:** `STABLE_CYCLES` = 4, an = FE, seg = 24, held 10 cycles -> after edge 4: `digits[3:0]` = 2, valid = 01, err = 00, exactly one update pulse with idx = 0.
- **Glitch rejection, then full scan:**
  - Hold an = FD, seg = 79 for 3 cycles, then change -> no update.
  - Then scan digits 0..7 with the patterns for values 0..7, each held 4 cycles -> digits = 76543210, valid = FF, 8 update pulses with idx 0..7 in order.
- **Illegal then legal:**
  - an = DF, seg = 7F held 4 cycles -> err = 20, valid and digits unchanged, one update pulse with idx = 5.
  - Then seg = 0E held 4 cycles -> nibble 5 = F, `err[5]` = 0, `valid[5]` = 1.
- **Bad anodes and blank:**
  - an = FC held 6 cycles -> `o_w_an_err` = 1, no update pulse.
  - Then an = FF held 6 cycles -> no state change and `o_w_an_err` still 1.
  - Then reset -> `o_w_an_err` = 0.
- **Reset mid-run:** an = F7, seg = 00 held; reset pulsed at cycle 2 -> no capture at the original edge 4; a capture (digit 3 = 8) occurs exactly 4 edges after reset releases.
